// File: rtl/msg_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : msg_frame_scheduler
// Purpose  : Multi-channel message framer. Each timing pulse starts a round
//            that visits every sensor channel in order. A channel with pending
//            data is drained from its byte FIFO and emitted upstream as a
//            128-bit header beat followed by MSB-first packed payload beats.
//            Empty channels are skipped, each channel is capped at MAX_BYTES
//            per round, upstream back-pressure stalls new reads, a channel
//            whose FIFO starves for TIMEOUT_CYC cycles is padded with zeros,
//            and start pulses that arrive mid-round are counted as overruns.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional build macro:
//   MSG_SCHED_CHECKSUM_EN - append a trailer beat after each channel's payload
//                           carrying the 16-bit sum of its payload bytes in
//                           [127:112].
// ----------------------------------------------------------------------------
// Ports:
//   sys_clk_i            system clock
//   rst_n_i              asynchronous active-low reset
//   timing_start_pulse_i one-cycle round trigger
//   msg_id_i             source id placed in every header
//   ch_id_i              per-channel {des_id, data_type, data_channel}
//   rd_en_o              one-hot FIFO read enables
//   din_i                FIFO read data (1-cycle read latency)
//   data_count_i         FIFO occupancy per channel
//   empty_i              FIFO empty flags
//   us_wr_en_o           upstream write strobe
//   us_wr_dout_o         upstream write data
//   us_prog_full_i       upstream back-pressure
//   busy_o               round in progress
//   frame_cnt_o          completed-round counter
//   overrun_cnt_o        start pulses dropped while busy (saturating)
//   timeout_err_o        sticky starvation flag
// ============================================================================
module msg_frame_scheduler #(
  parameter int          CH_NUM      = 25,
  parameter int          CNT_W       = 16,
  parameter int          MAX_BYTES   = 4096,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] HEADER_WORD = 32'hFDF7_EB90,
  parameter logic [3:0]  FRAME_TYPE  = 4'h1
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_n_i,
  input  logic                      timing_start_pulse_i,
  input  logic [7:0]                msg_id_i,
  input  logic [CH_NUM*24-1:0]      ch_id_i,
  output logic [CH_NUM-1:0]         rd_en_o,
  input  logic [CH_NUM*8-1:0]       din_i,
  input  logic [CH_NUM*CNT_W-1:0]   data_count_i,
  input  logic [CH_NUM-1:0]         empty_i,
  output logic                      us_wr_en_o,
  output logic [127:0]              us_wr_dout_o,
  input  logic                      us_prog_full_i,
  output logic                      busy_o,
  output logic [15:0]               frame_cnt_o,
  output logic [15:0]               overrun_cnt_o,
  output logic                      timeout_err_o
);

  // Starvation counter only has to reach TIMEOUT_CYC-1.
  localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     MAX_LEN = 16'(MAX_BYTES);
  localparam logic [7:0]      LAST_CH = 8'(CH_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HEADER,
    ST_READ,
    ST_NEXT
`ifdef MSG_SCHED_CHECKSUM_EN
    ,
    ST_TRAIL
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                ch_q, ch_d;
  logic [CH_NUM*CNT_W-1:0]   snap_q;
  logic [15:0]               len_q, len_d;
  logic [15:0]               issued_q, issued_d;   // reads + pads issued
  logic [15:0]               recv_q, recv_d;       // bytes packed so far
  logic                      pend_q, pend_d;       // a byte lands this cycle
  logic                      pad_q, pad_d;         // ...and it is a pad byte
  logic [127:0]              pack_q, pack_d;
  logic [3:0]                pidx_q, pidx_d;
  logic                      wr_en_q, wr_en_d;
  logic [127:0]              wr_dout_q, wr_dout_d;
  logic [TO_W-1:0]           starve_q, starve_d;
  logic                      tmo_q, tmo_d;         // current channel timed out
  logic                      terr_q, terr_d;
  logic [15:0]               fcnt_q, fcnt_d;
  logic [15:0]               ocnt_q, ocnt_d;
`ifdef MSG_SCHED_CHECKSUM_EN
  logic [15:0]               cks_q, cks_d;
`endif

  // Per-channel selects for the channel currently being served.
  logic [CNT_W-1:0]          w_snap_sel;
  logic                      w_empty_sel;
  logic [7:0]                w_din_sel;
  logic [23:0]               w_chid_sel;

  always_comb begin
    w_snap_sel  = '0;
    w_empty_sel = 1'b0;
    w_din_sel   = '0;
    w_chid_sel  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_q == 8'(k)) begin
        w_snap_sel  = snap_q[k*CNT_W +: CNT_W];
        w_empty_sel = empty_i[k];
        w_din_sel   = din_i[k*8 +: 8];
        w_chid_sel  = ch_id_i[k*24 +: 24];
      end
    end
  end

  logic [31:0] w_snap_ext;
  logic [15:0] w_len;
  assign w_snap_ext = 32'(w_snap_sel);
  assign w_len      = (w_snap_ext > 32'(MAX_BYTES)) ? MAX_LEN : w_snap_ext[15:0];

  // Issue decision: pads replace reads once the channel has timed out, and
  // both are stalled by back-pressure. Starvation counts only cycles where
  // the empty flag is the sole reason for withholding a read.
  logic w_can, w_rd, w_pad, w_starve;
  assign w_can    = (state_q == ST_READ) && !us_prog_full_i && (issued_q < len_q);
  assign w_rd     = w_can && !tmo_q && !w_empty_sel;
  assign w_pad    = w_can && tmo_q;
  assign w_starve = w_can && !tmo_q && w_empty_sel;

  always_comb begin
    rd_en_o = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (w_rd && (ch_q == 8'(k))) rd_en_o[k] = 1'b1;
    end
  end

  // Byte landing this cycle, inserted at byte slot pidx_q counted from MSB.
  logic [7:0]   w_byte;
  logic [15:0]  w_recv_nx;
  logic         w_last;
  logic [127:0] w_packed;
  assign w_byte    = pad_q ? 8'h00 : w_din_sel;
  assign w_recv_nx = recv_q + 16'd1;
  assign w_last    = (w_recv_nx == len_q);
  assign w_packed  = pack_q | ({w_byte, 120'd0} >> {pidx_q, 3'b000});

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    len_d     = len_q;
    issued_d  = issued_q;
    recv_d    = recv_q;
    pend_d    = 1'b0;
    pad_d     = 1'b0;
    pack_d    = pack_q;
    pidx_d    = pidx_q;
    wr_en_d   = 1'b0;
    wr_dout_d = wr_dout_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    terr_d    = terr_q;
    fcnt_d    = fcnt_q;
    ocnt_d    = ocnt_q;
`ifdef MSG_SCHED_CHECKSUM_EN
    cks_d     = cks_q;
`endif

    if (timing_start_pulse_i && (state_q != ST_IDLE) && (ocnt_q != 16'hFFFF)) begin
      ocnt_d = ocnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (timing_start_pulse_i) begin
          state_d = ST_SCAN;
          ch_d    = 8'd0;
        end
      end

      ST_SCAN: begin
        len_d    = w_len;
        issued_d = 16'd0;
        recv_d   = 16'd0;
        pack_d   = '0;
        pidx_d   = 4'd0;
        starve_d = '0;
        tmo_d    = 1'b0;
`ifdef MSG_SCHED_CHECKSUM_EN
        cks_d    = 16'd0;
`endif
        state_d  = (w_len == 16'd0) ? ST_NEXT : ST_HEADER;
      end

      ST_HEADER: begin
        if (!us_prog_full_i) begin
          wr_en_d   = 1'b1;
          wr_dout_d = {HEADER_WORD, FRAME_TYPE, 4'h0, fcnt_q, msg_id_i,
                       w_chid_sel, ch_q, len_q, 16'h0000};
          state_d   = ST_READ;
        end
      end

      ST_READ: begin
        if (w_rd || w_pad) begin
          issued_d = issued_q + 16'd1;
          pend_d   = 1'b1;
          pad_d    = w_pad;
        end

        if (w_starve) begin
          if (starve_q == TO_LAST) begin
            tmo_d    = 1'b1;
            terr_d   = 1'b1;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end

        // The in-flight byte is always captured, even under back-pressure.
        if (pend_q) begin
          recv_d = w_recv_nx;
`ifdef MSG_SCHED_CHECKSUM_EN
          cks_d  = cks_q + {8'h00, w_byte};
`endif
          if ((pidx_q == 4'd15) || w_last) begin
            wr_en_d   = 1'b1;
            wr_dout_d = w_packed;
            pack_d    = '0;
            pidx_d    = 4'd0;
          end else begin
            pack_d = w_packed;
            pidx_d = pidx_q + 4'd1;
          end
          if (w_last) begin
`ifdef MSG_SCHED_CHECKSUM_EN
            state_d = ST_TRAIL;
`else
            state_d = ST_NEXT;
`endif
          end
        end
      end

`ifdef MSG_SCHED_CHECKSUM_EN
      ST_TRAIL: begin
        if (!us_prog_full_i) begin
          wr_en_d   = 1'b1;
          wr_dout_d = {cks_q, 112'd0};
          state_d   = ST_NEXT;
        end
      end
`endif

      ST_NEXT: begin
        if (ch_q == LAST_CH) begin
          fcnt_d  = fcnt_q + 16'd1;
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + 8'd1;
          state_d = ST_SCAN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ch_q      <= 8'd0;
      snap_q    <= '0;
      len_q     <= 16'd0;
      issued_q  <= 16'd0;
      recv_q    <= 16'd0;
      pend_q    <= 1'b0;
      pad_q     <= 1'b0;
      pack_q    <= '0;
      pidx_q    <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_dout_q <= '0;
      starve_q  <= '0;
      tmo_q     <= 1'b0;
      terr_q    <= 1'b0;
      fcnt_q    <= 16'd0;
      ocnt_q    <= 16'd0;
`ifdef MSG_SCHED_CHECKSUM_EN
      cks_q     <= 16'd0;
`endif
    end else begin
      if ((state_q == ST_IDLE) && timing_start_pulse_i) begin
        snap_q <= data_count_i;
      end
      state_q   <= state_d;
      ch_q      <= ch_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      recv_q    <= recv_d;
      pend_q    <= pend_d;
      pad_q     <= pad_d;
      pack_q    <= pack_d;
      pidx_q    <= pidx_d;
      wr_en_q   <= wr_en_d;
      wr_dout_q <= wr_dout_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      terr_q    <= terr_d;
      fcnt_q    <= fcnt_d;
      ocnt_q    <= ocnt_d;
`ifdef MSG_SCHED_CHECKSUM_EN
      cks_q     <= cks_d;
`endif
    end
  end

  assign us_wr_en_o    = wr_en_q;
  assign us_wr_dout_o  = wr_dout_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_cnt_o   = fcnt_q;
  assign overrun_cnt_o = ocnt_q;
  assign timeout_err_o = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_frame_scheduler
// Purpose  : Self-checking bench for msg_frame_scheduler. Byte FIFOs are
//            modelled per channel; expected upstream beats for each round are
//            built from the FIFO contents and snapshot counts before the
//            round starts, then compared with the captured upstream stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_frame_scheduler;

  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int MAXB = 48;
  localparam int TOC  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               pf = 1'b0;
  logic [7:0]         msg_id = 8'h00;
  logic [CH*24-1:0]   ch_id = '0;
  logic [CH-1:0]      rd_en;
  logic [CH*8-1:0]    din = '0;
  logic [CH*CW-1:0]   dcnt;
  logic [CH-1:0]      empty;
  logic               wr_en;
  logic [127:0]       wr_dout;
  logic               busy;
  logic [15:0]        fcnt;
  logic [15:0]        ocnt;
  logic               terr;

  always #5 clk = ~clk;

  msg_frame_scheduler #(
    .CH_NUM(CH), .CNT_W(CW), .MAX_BYTES(MAXB), .TIMEOUT_CYC(TOC),
    .HEADER_WORD(32'hFDF7_EB90), .FRAME_TYPE(4'h1)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .timing_start_pulse_i(start),
    .msg_id_i(msg_id), .ch_id_i(ch_id), .rd_en_o(rd_en), .din_i(din),
    .data_count_i(dcnt), .empty_i(empty), .us_wr_en_o(wr_en),
    .us_wr_dout_o(wr_dout), .us_prog_full_i(pf), .busy_o(busy),
    .frame_cnt_o(fcnt), .overrun_cnt_o(ocnt), .timeout_err_o(terr)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] mem [CH][1024];
  int         head [CH];
  int         tail [CH];
  int         extra [CH];   // added to reported count to fake starvation
  logic       flush = 1'b0;
  int         viol = 0;

  always @(posedge clk) begin
    if ($countones(rd_en) > 1) viol++;
    for (int k = 0; k < CH; k++) begin
      if (flush) head[k] = tail[k];
      else if (rd_en[k]) begin
        if (head[k] == tail[k]) viol++;
        else begin
          din[k*8 +: 8] <= mem[k][head[k] & 1023];
          head[k] = head[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < CH; k++) begin
      empty[k]          = (tail[k] == head[k]);
      dcnt[k*CW +: CW]  = CW'(tail[k] - head[k] + extra[k]);
    end
  end

  logic [127:0] obs [$];
  always @(negedge clk) begin
    if (rst_n && wr_en) obs.push_back(wr_dout);
  end

  task automatic push_byte(input int k, input logic [7:0] b);
    mem[k][tail[k] & 1023] = b;
    tail[k] = tail[k] + 1;
  endtask

  task automatic push_rand(input int k, input int n);
    for (int i = 0; i < n; i++) push_byte(k, 8'($urandom_range(0, 255)));
  endtask

  task automatic do_flush();
    for (int k = 0; k < CH; k++) extra[k] = 0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // ---------------- reference model + round driver ----------------
  int model_fc = 0;
  bit bp_rand  = 1'b0;

  task automatic do_round(input string tag, input int extra_at, input int hold_ch,
                          output int hold_rd, output int hold_seen);
    logic [127:0] exq [$];
    logic [127:0] beat;
    logic [7:0]   b;
    logic [15:0]  sum;
    int avail, snap, len, base, n, hs;
    bit in_hold, in_hold_prev;

    for (int c = 0; c < CH; c++) begin
      avail = tail[c] - head[c];
      snap  = avail + extra[c];
      len   = (snap > MAXB) ? MAXB : snap;
      if (len == 0) continue;
      exq.push_back({32'hFDF7_EB90, 4'h1, 4'h0, 16'(model_fc), msg_id,
                     ch_id[c*24 +: 24], 8'(c), 16'(len), 16'h0000});
      beat = '0;
      sum  = 16'h0000;
      for (int i = 0; i < len; i++) begin
        b = (i < avail) ? mem[c][(head[c] + i) & 1023] : 8'h00;
        sum = sum + {8'h00, b};
        beat[127 - 8*(i % 16) -: 8] = b;
        if ((i % 16 == 15) || (i == len - 1)) begin
          exq.push_back(beat);
          beat = '0;
        end
      end
`ifdef MSG_SCHED_CHECKSUM_EN
      exq.push_back({sum, 112'd0});
`endif
    end

    base = obs.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; hs = -1; hold_rd = 0; hold_seen = 0; in_hold_prev = 1'b0;
    while (busy && n < 4000) begin
      if (hold_ch >= 0) begin
        if (in_hold_prev && rd_en[hold_ch]) hold_rd++;
        if (hs < 0 && rd_en[hold_ch]) hs = n + 3;
      end
      in_hold = (hs >= 0) && (n >= hs) && (n < hs + 50);
      if (in_hold) hold_seen++;
      start = (n == extra_at);
      pf    = in_hold ? 1'b1 : (bp_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
      in_hold_prev = in_hold;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    pf    = 1'b0;
    check({tag, "_done"}, 128'(n < 4000), 128'd1);
    @(negedge clk);
    #2;
    check({tag, "_nbeats"}, 128'(obs.size() - base), 128'(exq.size()));
    for (int i = 0; i < exq.size(); i++) begin
      if (base + i < obs.size())
        check($sformatf("%s_beat%0d", tag, i), obs[base + i], exq[i]);
    end
    model_fc++;
    check({tag, "_fcnt"}, 128'(fcnt), 128'(16'(model_fc)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hr, hsn, cnt, found;
    logic [127:0] last;

    msg_id = 8'($urandom_range(0, 255));
    ch_id  = {32'($urandom), 32'($urandom), 32'($urandom)};
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",  128'(busy),    128'd0);
    check("rst_wr_en", 128'(wr_en),   128'd0);
    check("rst_dout",  wr_dout,       128'd0);
    check("rst_rd_en", 128'(rd_en),   128'd0);
    check("rst_fcnt",  128'(fcnt),    128'd0);
    check("rst_ocnt",  128'(ocnt),    128'd0);
    check("rst_terr",  128'(terr),    128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two non-empty channels out of four, plus a pulse while busy.
    do_flush();
    push_rand(1, 5);
    push_rand(3, 20);
    do_round("basic", 3, -1, hr, hsn);
    check("overrun", 128'(ocnt), 128'd1);

    // Byte cap: remainder stays in the FIFO.
    do_flush();
    push_rand(0, 60);
    do_round("cap", -1, -1, hr, hsn);
    check("cap_left", 128'(tail[0] - head[0]), 128'(MAXB > 60 ? 0 : 60 - MAXB));

    // Back-pressure hold mid-read.
    do_flush();
    push_rand(2, 40);
    do_round("hold", -1, 2, hr, hsn);
    check("hold_rd",   128'(hr),  128'd0);
    check("hold_seen", 128'(hsn), 128'd50);

    // Starvation: 10 reported, only 3 present.
    do_flush();
    check("terr_pre", 128'(terr), 128'd0);
    push_rand(1, 3);
    extra[1] = 7;
    do_round("starve", -1, -1, hr, hsn);
    check("terr", 128'(terr), 128'd1);
    extra[1] = 0;

`ifdef MSG_SCHED_CHECKSUM_EN
    do_flush();
    push_byte(0, 8'hFF);
    push_byte(0, 8'h01);
    push_byte(0, 8'h10);
    do_round("cks", -1, -1, hr, hsn);
    last = obs[obs.size() - 1];
    check("cks_trailer", 128'(last[127:112]), 128'h0110);
`endif

    // Randomized rounds with random back-pressure.
    bp_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      do_flush();
      for (int k = 0; k < CH; k++) begin
        cnt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
        push_rand(k, cnt);
      end
      do_round($sformatf("rnd%0d", r), -1, -1, hr, hsn);
    end
    bp_rand = 1'b0;

    // Reset in the middle of a read.
    do_flush();
    push_rand(0, 40);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (rd_en[0]) found = 1;
      else @(negedge clk);
    end
    check("mid_rd_seen", 128'(found), 128'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy",  128'(busy),  128'd0);
    check("mid_wr_en", 128'(wr_en), 128'd0);
    check("mid_rd_en", 128'(rd_en), 128'd0);
    check("mid_fcnt",  128'(fcnt),  128'd0);
    check("mid_ocnt",  128'(ocnt),  128'd0);
    check("mid_terr",  128'(terr),  128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_fc = 0;

    do_flush();
    push_rand(0, 2);
    push_rand(3, 18);
    do_round("post", -1, -1, hr, hsn);

    check("rd_viol", 128'(viol), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_frame_scheduler.md
Name: msg_frame_scheduler

Overview:
- Next-generation multi-channel message transmitter. Each round is triggered by a timing pulse.
- For every sensor channel with pending data, it drains that channel's byte FIFO and emits one framed message into the 128-bit upstream FIFO: a header beat, then packed payload beats.
- Replaces the per-channel driver bank with a single parametrised scheduler that has:
  - empty-channel skipping
  - a per-channel byte cap
  - upstream back-pressure
  - a starvation timeout
  - overrun counting

Parameters:
CH_NUM, 25, number of sensor channels (1..255)
CNT_W, 16, width of each per-channel FIFO data count
MAX_BYTES, 4096, per-channel byte cap per round (must be < 2**16)
TIMEOUT_CYC, 1024, cycles a starved read may wait before padding
HEADER_WORD, 32'hFDF7_EB90, frame sync word
FRAME_TYPE, 4'h1, frame type nibble

Ports:
sys_clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
timing_start_pulse_i  in  1  one-cycle round trigger
msg_id_i  in  8  source id placed in every header
ch_id_i  in  CH_NUM*24  per channel {des_id, data_type, data_channel}; channel k at [k*24+:24]
rd_en_o  out  CH_NUM  one-hot FIFO read enables
din_i  in  CH_NUM*8  FIFO read data; 1-cycle read latency
data_count_i  in  CH_NUM*CNT_W  FIFO occupancy
empty_i  in  CH_NUM  FIFO empty flags
us_wr_en_o  out  1  upstream write strobe
us_wr_dout_o  out  128  upstream write data
us_prog_full_i  in  1  upstream back-pressure
busy_o  out  1  round in progress
frame_cnt_o  out  16  completed-round counter
overrun_cnt_o  out  16  start pulses dropped while busy
timeout_err_o  out  1  sticky; set on any starvation pad

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- Snapshot: on timing_start_pulse_i in IDLE, latch data_count_i and go to SCAN.
- Busy overrun: a pulse while busy_o=1 is ignored and increments overrun_cnt_o (saturating at 16'hFFFF).
- States:
  - IDLE: waiting for a start pulse.
  - SCAN: evaluates channel ch (starting at 0).
    - len = min(snapshot[ch], MAX_BYTES).
    - len=0 -> skip to next channel in 1 cycle.
    - len>0 -> HEADER.
  - HEADER: waits while us_prog_full_i=1, then writes one beat. Layout:
    - [127:96] HEADER_WORD
    - [95:92] FRAME_TYPE
    - [91:88] 0
    - [87:72] frame_cnt_o
    - [71:64] msg_id_i
    - [63:40] ch_id_i of ch
    - [39:32] ch
    - [31:16] len
    - [15:0] 0
    - Then go to READ.
  - READ: asserts rd_en_o[ch] only when all of these hold:
    - us_prog_full_i=0
    - empty_i[ch]=0
    - bytes issued < len
    - Bytes returned one cycle later are packed MSB-first: first byte at [127:120].
    - A beat is written when 16 bytes are packed, or when the last byte of len arrives. A partial final beat is zero-padded in the low bytes.
    - Back-pressure stops new reads only; the single in-flight byte is still captured.
    - Once all len bytes are written, go to NEXT.
  - Starvation: if rd_en_o[ch] is withheld solely because of empty_i for TIMEOUT_CYC consecutive cycles:
    - the remaining bytes are substituted with 8'h00 without reading;
    - timeout_err_o is set;
    - the beat count still matches len.
  - NEXT:
    - ch == CH_NUM-1 -> increment frame_cnt_o (wraps 16'hFFFF -> 0) and return to IDLE. This happens even if every channel was skipped.
    - Otherwise ch+1 -> SCAN.
- Write path: us_wr_en_o/us_wr_dout_o are registered, 1 cycle after the beat is formed. us_wr_en_o is never asserted in a cycle in which us_prog_full_i was sampled 1 before the beat was committed, except for the beat completing an in-flight byte.
- Read enables: at most one rd_en_o bit is high per cycle; never while empty_i of that channel is 1.
- busy_o: 1 from the cycle after the start pulse until IDLE is re-entered.
- Mid-operation reset: everything returns to reset values immediately; no partial beat is emitted.
- timeout_err_o clears only on reset.

Optional Feature:
MSG_SCHED_CHECKSUM_EN
- Defined:
  - After the last payload beat of each channel, one trailer beat is written: [127:112] = 16-bit modular sum of that channel's payload bytes (pad bytes included), [111:0] = 0.
  - The trailer obeys back-pressure like any beat.
  - The header len field is unchanged; it excludes the trailer.
- Undefined: no trailer beat and no checksum logic.

Test Plan:
- CH_NUM=4, counts {0,5,0,20}, pulse -> exactly two messages:
  - ch1: header (len=5, [39:32]=1), 1 payload beat, bytes in [127:88], low 11 bytes zero.
  - ch3: header (len=20), 2 payload beats (16 + 4 bytes).
  - frame_cnt_o 0->1.
- MAX_BYTES=16, count 40 on ch0 -> header len=16, one payload beat, 16 rd_en pulses; FIFO keeps 24 bytes.
- Hold us_prog_full_i high for 50 cycles mid-READ on a 64-byte channel -> no rd_en_o during hold; payload byte order is continuous; total 4 payload beats.
- Snapshot 10 bytes but empty_i stays 1 after 3 reads, TIMEOUT_CYC=8 -> after 8 starved cycles the last 7 bytes are 00; timeout_err_o=1; one payload beat.
- Second pulse during a busy round -> overrun_cnt_o=1; round unaffected. Drive rst_n_i low mid-READ -> all outputs 0 next edge; new pulse restarts at ch0 with frame_cnt 0.
- With MSG_SCHED_CHECKSUM_EN, 3 bytes 8'hFF,8'h01,8'h10 -> trailer [127:112]=16'h0110.
